// File: rtl/pads_cfg_pkg.sv
// Pad output-enable table sequencer: shared constants and types.
// Used by the scan FSM and its single-transfer Wishbone engine.
package pads_cfg_pkg;

  localparam logic [31:0] PAD_CFG_BASE = 32'h3000_6000;
  localparam int          NUM_CFG_PADS = 38;
  localparam logic [3:0]  WB_SEL       = 4'hF;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SCAN = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN,
    S_WR   = ST_WR,
    S_RD   = ST_RD,
    S_GAP  = ST_GAP,
    S_DONE = ST_DONE,
    S_ERR  = ST_ERR
  } state_t;

endpackage

// File: rtl/pads_cfg_wb_xfer.sv
// Single Wishbone transaction engine with ack timeout.
// Bus outputs are registered; completion is reported combinationally.
module pads_cfg_wb_xfer
  import pads_cfg_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat,
  output logic        ack_done,
  output logic        timeout,
  output logic        rdata,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  input  logic [31:0] m_dat_i
);

  logic [15:0] cnt;
  logic        gap;
  logic        unused_dat;

  // an ack during the idle cycle after a transfer belongs to that transfer
  assign ack_done   = m_stb_o & m_ack_i & ~gap;
  assign timeout    = m_stb_o & ~m_ack_i
                    & (cnt == 16'(TIMEOUT - 1));
  assign rdata      = m_dat_i[0];
  assign unused_dat = ^m_dat_i[31:1];

  // launch, hold and retire one bus transaction
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      cnt     <= '0;
      gap     <= 1'b0;
    end else begin
      gap <= 1'b0;
      if (m_stb_o) begin
        if (ack_done || timeout) begin
          m_cyc_o <= 1'b0;
          m_stb_o <= 1'b0;
          m_we_o  <= 1'b0;
          m_sel_o <= '0;
          m_adr_o <= '0;
          m_dat_o <= '0;
          gap     <= 1'b1;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end else if (req) begin
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= we;
        m_sel_o <= WB_SEL;
        m_adr_o <= adr;
        m_dat_o <= dat;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: rtl/pads_cfg_sequencer.sv
// Walks the pad OEN table, writing (and optionally verifying) each
// masked pad over Wishbone; reports busy, done pulse, sticky error.
module pads_cfg_sequencer
  import pads_cfg_pkg::*;
#(
  parameter int          NUM_PADS  = NUM_CFG_PADS,
  parameter logic [31:0] BASE_ADDR = PAD_CFG_BASE,
  parameter int          TIMEOUT   = 16,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                start,
  input  logic [NUM_PADS-1:0] cfg_oen,
  input  logic [NUM_PADS-1:0] cfg_mask,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [5:0]          err_idx,
  output logic                m_cyc_o,
  output logic                m_stb_o,
  output logic                m_we_o,
  output logic [3:0]          m_sel_o,
  output logic [31:0]         m_adr_o,
  output logic [31:0]         m_dat_o,
  input  logic                m_ack_i,
  input  logic [31:0]         m_dat_i
);

  localparam logic [5:0] LAST = 6'(NUM_PADS - 1);

  state_t              state;
  logic [5:0]          idx;
  logic [NUM_PADS-1:0] oen_q;
  logic [NUM_PADS-1:0] mask_q;
  logic                rd_next;
  logic                req;
  logic                req_we;
  logic                ack_done;
  logic                timeout;
  logic                rdata;
  logic [31:0]         adr;
  logic [31:0]         dat;

  assign adr = BASE_ADDR | {26'b0, idx};
  assign dat = {31'b0, oen_q[idx]};

  // request a write from SCAN, the verify read from GAP
  always_comb begin
    req    = 1'b0;
    req_we = 1'b0;
    unique case (state)
      S_SCAN: begin
        req    = mask_q[idx];
        req_we = 1'b1;
      end
      S_GAP:   req = rd_next;
      default: req = 1'b0;
    endcase
  end

  pads_cfg_wb_xfer #(
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .clk      (clk),
    .resetb   (resetb),
    .req      (req),
    .we       (req_we),
    .adr      (adr),
    .dat      (dat),
    .ack_done (ack_done),
    .timeout  (timeout),
    .rdata    (rdata),
    .m_cyc_o  (m_cyc_o),
    .m_stb_o  (m_stb_o),
    .m_we_o   (m_we_o),
    .m_sel_o  (m_sel_o),
    .m_adr_o  (m_adr_o),
    .m_dat_o  (m_dat_o),
    .m_ack_i  (m_ack_i),
    .m_dat_i  (m_dat_i)
  );

  // scan FSM with latched config and registered status
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state   <= S_IDLE;
      idx     <= '0;
      oen_q   <= '0;
      mask_q  <= '0;
      rd_next <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_idx <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            oen_q   <= cfg_oen;
            mask_q  <= cfg_mask;
            idx     <= '0;
            rd_next <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (mask_q[idx]) begin
            state <= S_WR;
          end else if (idx == LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        S_WR: begin
          if (timeout) begin
            err     <= 1'b1;
            err_idx <= idx;
            busy    <= 1'b0;
            state   <= S_ERR;
          end else if (ack_done) begin
            rd_next <= VERIFY;
            state   <= S_GAP;
          end
        end
        S_RD: begin
          if (timeout || (ack_done && rdata != oen_q[idx])) begin
            err     <= 1'b1;
            err_idx <= idx;
            busy    <= 1'b0;
            state   <= S_ERR;
          end else if (ack_done) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (rd_next) begin
            rd_next <= 1'b0;
            state   <= S_RD;
          end else if (idx == LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            idx   <= idx + 6'd1;
            state <= S_SCAN;
          end
        end
        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pads_cfg_sequencer.sv
// Bench for pads_cfg_sequencer: vector table plus scoreboard of
// expected bus transactions, and a reset-mid-transfer sequence.
module tb_pads_cfg_sequencer;
  import pads_cfg_pkg::*;

  localparam int          NP   = NUM_CFG_PADS;
  localparam logic [31:0] BASE = 32'h3000_6000;
  localparam int          TO   = 16;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic [1:0]    start;
  logic [NP-1:0] cfg_oen;
  logic [NP-1:0] cfg_mask;
  logic [1:0]    busy, done, err, cyc, stb, we, ack;
  logic [5:0]    err_idx [2];
  logic [3:0]    sel [2];
  logic [31:0]   adr [2];
  logic [31:0]   dat [2];
  logic [31:0]   rdat [2];

  int lat = 1;
  int hang = -1;
  int inv = -1;
  int checks = 0;
  int errors = 0;
  int ntx = 0;

  logic       mem [2][64];
  logic [7:0] scnt [2];

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic        d;
  } tx_t;

  typedef struct {
    int            k;
    logic [NP-1:0] mask;
    logic [NP-1:0] oen;
    int            hang;
    int            inv;
    int            lat;
    bit            exp_err;
    int            exp_idx;
  } vec_t;

  tx_t  exp_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  pads_cfg_sequencer #(.VERIFY(1'b1)) u_ver (
    .clk(clk), .resetb(resetb), .start(start[0]),
    .cfg_oen(cfg_oen), .cfg_mask(cfg_mask),
    .busy(busy[0]), .done(done[0]), .err(err[0]),
    .err_idx(err_idx[0]),
    .m_cyc_o(cyc[0]), .m_stb_o(stb[0]), .m_we_o(we[0]),
    .m_sel_o(sel[0]), .m_adr_o(adr[0]), .m_dat_o(dat[0]),
    .m_ack_i(ack[0]), .m_dat_i(rdat[0])
  );

  pads_cfg_sequencer #(.VERIFY(1'b0)) u_wo (
    .clk(clk), .resetb(resetb), .start(start[1]),
    .cfg_oen(cfg_oen), .cfg_mask(cfg_mask),
    .busy(busy[1]), .done(done[1]), .err(err[1]),
    .err_idx(err_idx[1]),
    .m_cyc_o(cyc[1]), .m_stb_o(stb[1]), .m_we_o(we[1]),
    .m_sel_o(sel[1]), .m_adr_o(adr[1]), .m_dat_o(dat[1]),
    .m_ack_i(ack[1]), .m_dat_i(rdat[1])
  );

  // registered-ack slave: ack after lat cycles of stb, lingers one cycle
  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int k = 0; k < 2; k++) begin
        ack[k]  <= 1'b0;
        scnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cyc[k] && stb[k] && int'(adr[k][5:0]) != hang) begin
          ack[k]  <= (int'(scnt[k]) >= lat - 1);
          scnt[k] <= scnt[k] + 8'd1;
          if (ack[k] && we[k])
            mem[k][adr[k][5:0]] <= dat[k][0];
        end else begin
          ack[k]  <= 1'b0;
          scnt[k] <= '0;
        end
      end
    end
  end

  assign rdat[0] = {31'b0, mem[0][adr[0][5:0]]
                   ^ (int'(adr[0][5:0]) == inv)};
  assign rdat[1] = {31'b0, mem[1][adr[1][5:0]]
                   ^ (int'(adr[1][5:0]) == inv)};

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance one cycle and score any transaction completing in it
  task automatic tick();
    tx_t e;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (resetb && cyc[k] && stb[k] && ack[k]) begin
        ntx++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx: inst %0d adr %h required none",
                   k, adr[k]);
        end else begin
          e = exp_q.pop_front();
          chk("tx_we", we[k], e.we);
          chk("tx_adr", adr[k], e.adr);
          chk("tx_sel", sel[k], 4'hF);
          if (e.we) chk("tx_dat", dat[k], {31'b0, e.d});
        end
      end
    end
  endtask

  task automatic run(vec_t v);
    int  k;
    int  t;
    int  pc;
    int  nexp;
    int  n0;
    int  ndone;
    int  run_len;
    int  last_len;
    int  stb_after;
    int  exp_t;
    bit  saw_err;
    k = v.k;
    cfg_mask = v.mask;
    cfg_oen  = v.oen;
    lat  = v.lat;
    hang = v.hang;
    inv  = v.inv;
    exp_q.delete();
    pc = 0;
    for (int p = 0; p < NP; p++) begin
      if (v.mask[p]) begin
        pc++;
        if (p == v.hang) break;
        exp_q.push_back('{1'b1, BASE | 32'(p), v.oen[p]});
        if (k == 0) exp_q.push_back('{1'b0, BASE | 32'(p), 1'b0});
        if (p == v.inv && k == 0) break;
      end
    end
    exp_t = NP + 1 + pc * (v.lat + 2) * ((k == 0) ? 2 : 1);
    nexp = exp_q.size();
    n0 = ntx;
    t = 0;
    ndone = 0;
    run_len = 0;
    last_len = 0;
    saw_err = 1'b0;
    start[k] = 1'b1;
    while (t < 2000 && !saw_err && ndone == 0) begin
      tick();
      t++;
      if (t == 1) begin
        start[k] = 1'b0;
        chk("busy_after_start", busy[k], 1);
        chk("err_cleared_by_start", err[k], 0);
      end
      if (stb[k]) run_len++;
      else if (run_len != 0) begin
        last_len = run_len;
        run_len = 0;
      end
      if (done[k]) ndone++;
      if (err[k]) saw_err = 1'b1;
    end
    if (v.exp_err) begin
      chk("err_flag", saw_err, 1);
      chk("err_idx", err_idx[k], 64'(v.exp_idx));
      chk("busy_in_err", busy[k], 0);
      if (v.hang >= 0) chk("timeout_stb_len", last_len, TO);
      stb_after = 0;
      for (int i = 0; i < 24; i++) begin
        tick();
        if (done[k]) ndone++;
        if (stb[k] || cyc[k]) stb_after++;
      end
      chk("no_done_on_err", ndone, 0);
      chk("no_bus_after_err", stb_after, 0);
      chk("err_sticky", err[k], 1);
    end else begin
      chk("done_cycle", t, exp_t);
      chk("busy_at_done", busy[k], 0);
      for (int i = 0; i < 4; i++) begin
        tick();
        if (done[k]) ndone++;
      end
      chk("done_once", ndone, 1);
      chk("err_clear", err[k], 0);
    end
    chk("queue_empty", exp_q.size(), 0);
    chk("tx_count", ntx - n0, nexp);
  endtask

  initial begin
    int  n0;
    bit  found;
    logic [NP-1:0] all1;
    all1 = '1;
    start = '0;
    cfg_oen = '0;
    cfg_mask = '0;
    vecs[0] = '{0, all1, 38'h3F_FFC0_007D, -1, -1, 1, 1'b0, 0};
    vecs[1] = '{1, 38'h40, 38'h0, -1, -1, 1, 1'b0, 0};
    vecs[2] = '{0, all1, 38'h3F_FFC0_007D, 3, -1, 1, 1'b1, 3};
    vecs[3] = '{0, all1, 38'h2A_1234_5678, -1, 21, 1, 1'b1, 21};
    vecs[4] = '{0, 38'h15_5555_5555, 38'h2A_1234_5678, -1, -1, 3,
                1'b0, 0};
    vecs[5] = '{0, 38'h0, 38'h3F_FFFF_FFFF, -1, -1, 1, 1'b0, 0};
    vecs[6] = '{1, all1, 38'h1F_0F0F_0F0F, 37, -1, 1, 1'b1, 37};
    vecs[7] = '{1, 38'h20_0000_0001, 38'h20_0000_0000, -1, -1, 2,
                1'b0, 0};

    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
      chk("rst_err", err[k], 0);
      chk("rst_err_idx", err_idx[k], 0);
      chk("rst_cyc_stb_we", {cyc[k], stb[k], we[k]}, 0);
      chk("rst_sel", sel[k], 0);
      chk("rst_adr", adr[k], 0);
      chk("rst_dat", dat[k], 0);
    end
    resetb = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run(vecs[i]);

    // start while busy is ignored; reset lands in the middle of pad 10
    cfg_mask = all1;
    cfg_oen  = 38'h2A_1234_5678;
    lat = 1;
    hang = -1;
    inv = -1;
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin
      exp_q.push_back('{1'b1, BASE | 32'(p), cfg_oen[p]});
      exp_q.push_back('{1'b0, BASE | 32'(p), 1'b0});
    end
    n0 = ntx;
    found = 1'b0;
    start[0] = 1'b1;
    for (int t = 1; t < 2000 && !found; t++) begin
      tick();
      if (t == 1) start[0] = 1'b0;
      if (t == 5) start[0] = 1'b1;
      if (t == 6) start[0] = 1'b0;
      if (cyc[0] && stb[0] && we[0] && adr[0] == (BASE | 32'd10))
        found = 1'b1;
    end
    chk("pad10_write_seen", found, 1);
    chk("tx_before_reset", ntx - n0, 20);
    resetb = 1'b0;
    #1;
    chk("mid_rst_cyc_stb_we", {cyc[0], stb[0], we[0]}, 0);
    chk("mid_rst_sel", sel[0], 0);
    chk("mid_rst_adr", adr[0], 0);
    chk("mid_rst_dat", dat[0], 0);
    chk("mid_rst_status", {busy[0], done[0], err[0]}, 0);
    chk("mid_rst_err_idx", err_idx[0], 0);
    exp_q.delete();
    tick();
    resetb = 1'b1;
    tick();
    run(vecs[5]);
    run(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
